dual_key_debounce: RTL

- Input-conditioning stage directly upstream of and_gate.
- Takes two raw, bouncy, asynchronous push-button/switch inputs and synchronises each to sys_clk.
- Debounces each channel independently and drives clean levels onto and_gate's A and B inputs.
- Optionally emits one-cycle press pulses per channel.

---
 rtl/dual_key_debounce.sv | 100 ++++++++++
 1 files changed

// File: rtl/dual_key_debounce.sv
// Two-channel synchroniser + debouncer feeding the and_gate A/B inputs.
// Define DBNC_PRESS_PULSE_EN to add registered one-cycle press pulses per channel.
module dual_key_debounce #(
    parameter int CNT_MAX     = 999_999,
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_a_raw,
    input  logic key_b_raw,
    output logic key_a,
    output logic key_b,
    output logic a_press,
    output logic b_press
);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [1:0] raw_vec;
    logic [1:0] key_vec;
    logic [1:0] press_vec;

    assign raw_vec = {key_b_raw, key_a_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;
            logic [CW-1:0]          cnt_q;
            logic [CW-1:0]          cnt_d;
            logic                   key_q;
            logic                   key_d;
            logic                   s;

            assign s = sync_q[SYNC_STAGES-1];

            // Any cycle where s agrees with key clears the count, so bounces never accumulate.
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], raw_vec[gi]};
                cnt_d  = '0;
                key_d  = key_q;
                if (s != key_q) begin
                    if (cnt_q == CNT_LAST) begin
                        key_d = s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    sync_q <= '0;
                    cnt_q  <= '0;
                    key_q  <= 1'b0;
                end else begin
                    sync_q <= sync_d;
                    cnt_q  <= cnt_d;
                    key_q  <= key_d;
                end
            end

            assign key_vec[gi] = key_q;

`ifdef DBNC_PRESS_PULSE_EN
            logic key_prev_q;
            logic key_prev_d;
            logic press_q;
            logic press_d;

            // Pulse lands one edge after key rises: compare key against its delayed copy.
            always_comb begin
                key_prev_d = key_q;
                press_d    = key_q & ~key_prev_q;
            end

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    key_prev_q <= 1'b0;
                    press_q    <= 1'b0;
                end else begin
                    key_prev_q <= key_prev_d;
                    press_q    <= press_d;
                end
            end

            assign press_vec[gi] = press_q;
`else
            assign press_vec[gi] = 1'b0;
`endif
        end
    endgenerate

    assign key_a   = key_vec[0];
    assign key_b   = key_vec[1];
    assign a_press = press_vec[0];
    assign b_press = press_vec[1];

endmodule
